// File: rtl/pine16_cpu_pkg.sv
// Shared pine16 core constants: register file geometry and the r0 reset value.
package pine16_cpu_pkg;
  localparam int          REG_AW    = 4;
  localparam int          REG_DW    = 16;
  localparam int          REG_NREAD = 2;
  localparam logic [15:0] R0_RESET  = 16'h0001;
endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: captures bypassed data and next-state busy on ren.
module regfile_rdport
  import pine16_cpu_pkg::*;
#(
  parameter int addr_width = REG_AW,
  parameter int data_width = REG_DW
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          ren,
  input  logic [addr_width-1:0]                         radr,
  input  logic [(1<<addr_width)-1:0][data_width-1:0]    regs,
  input  logic [(1<<addr_width)-1:0]                    busy_nxt,
  input  logic                                          we,
  input  logic [addr_width-1:0]                         wadr,
  input  logic [data_width-1:0]                         din,
  output logic [data_width-1:0]                         dout,
  output logic                                          dbusy
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout  <= '0;
      dbusy <= 1'b0;
    end else if (ren) begin
      // Same-edge write is forwarded so decode never sees stale data.
      dout  <= (we && wadr == radr) ? din : regs[radr];
      dbusy <= busy_nxt[radr];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// pine16 register file: one write port, NREAD registered read ports, busy scoreboard.
module regfile_mp
  import pine16_cpu_pkg::*;
#(
  parameter int addr_width = REG_AW,
  parameter int data_width = REG_DW,
  parameter int NREAD      = REG_NREAD,
  parameter int R0_INIT    = int'(R0_RESET)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        we,
  input  logic [addr_width-1:0]       wadr,
  input  logic [data_width-1:0]       din,
  input  logic                        rsv,
  input  logic [addr_width-1:0]       rsv_adr,
  input  logic [NREAD-1:0]            ren,
  input  logic [NREAD*addr_width-1:0] radr,
  output logic [NREAD*data_width-1:0] dout,
  output logic [NREAD-1:0]            dbusy
);

  localparam int DEPTH = 1 << addr_width;

  logic [DEPTH-1:0][data_width-1:0] regs;
  logic [DEPTH-1:0]                 busy, busy_nxt;

  // Reserve is applied after the write-clear: a new producer supersedes the completing one.
  always_comb begin
    busy_nxt = busy;
    if (we)  busy_nxt[wadr]    = 1'b0;
    if (rsv) busy_nxt[rsv_adr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs    <= '0;
      regs[0] <= data_width'(R0_INIT);
      busy    <= '0;
    end else begin
      if (we) regs[wadr] <= din;
      busy <= busy_nxt;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    regfile_rdport #(
      .addr_width(addr_width),
      .data_width(data_width)
    ) u_rdport (
      .clk     (clk),
      .reset   (reset),
      .ren     (ren[k]),
      .radr    (radr[k*addr_width +: addr_width]),
      .regs    (regs),
      .busy_nxt(busy_nxt),
      .we      (we),
      .wadr    (wadr),
      .din     (din),
      .dout    (dout[k*data_width +: data_width]),
      .dbusy   (dbusy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: array-level model compared every cycle plus directed literals.
module tb_regfile_mp;
  import pine16_cpu_pkg::*;

  localparam int AW = REG_AW;
  localparam int DW = REG_DW;
  localparam int NR = REG_NREAD;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              we = 1'b0, rsv = 1'b0;
  logic [AW-1:0]     wadr = '0, rsv_adr = '0;
  logic [DW-1:0]     din = '0;
  logic [NR-1:0]     ren = '0;
  logic [NR*AW-1:0]  radr = '0;
  wire  [NR*DW-1:0]  dout;
  wire  [NR-1:0]     dbusy;

  // Wide build: NREAD=4, data_width=32, shares the write/reserve controls.
  logic [3:0]        ren2 = '0;
  logic [15:0]       radr2 = '0;
  wire  [31:0]       din2 = {din, din};
  wire  [127:0]      dout2;
  wire  [3:0]        dbusy2;

  regfile_mp u_dut (
    .clk(clk), .reset(reset), .we(we), .wadr(wadr), .din(din),
    .rsv(rsv), .rsv_adr(rsv_adr), .ren(ren), .radr(radr),
    .dout(dout), .dbusy(dbusy)
  );

  regfile_mp #(.addr_width(4), .data_width(32), .NREAD(4), .R0_INIT(1)) u_dut2 (
    .clk(clk), .reset(reset), .we(we), .wadr(wadr), .din(din2),
    .rsv(rsv), .rsv_adr(rsv_adr), .ren(ren2), .radr(radr2),
    .dout(dout2), .dbusy(dbusy2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: register array and busy set updated by the behavioural rules.
  logic [DW-1:0] m_regs [16];
  bit            m_busy [16];
  logic [DW-1:0] m_dout [NR];
  bit            m_dbusy[NR];

  always @(posedge clk or negedge reset) begin : model
    bit nb [16];
    int ra;
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        m_regs[i] <= (i == 0) ? R0_RESET : '0;
        m_busy[i] <= 1'b0;
      end
      for (int k = 0; k < NR; k++) begin
        m_dout[k]  <= '0;
        m_dbusy[k] <= 1'b0;
      end
    end else begin
      nb = m_busy;
      if (we)  nb[wadr]    = 1'b0;
      if (rsv) nb[rsv_adr] = 1'b1;
      for (int k = 0; k < NR; k++) begin
        if (ren[k]) begin
          ra = int'(radr[k*AW +: AW]);
          m_dout[k]  <= (we && int'(wadr) == ra) ? din : m_regs[ra];
          m_dbusy[k] <= nb[ra];
        end
      end
      if (we) m_regs[wadr] <= din;
      m_busy <= nb;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NR; k++) begin
        check($sformatf("model port%0d dout", k), 64'(dout[k*DW +: DW]), 64'(m_dout[k]));
        check($sformatf("model port%0d dbusy", k), 64'(dbusy[k]), 64'(m_dbusy[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // 1 reset mid-cycle, then read r0 / r5
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("reset dout", 64'(dout), 64'h0);
    check("reset dbusy", 64'(dbusy), 64'h0);
    chk_en = 1'b1;
    tick();
    reset = 1'b1;
    ren = 2'b11; radr = {4'd5, 4'd0};
    tick();
    check("r0 init", 64'(dout[15:0]), 64'h0001);
    check("r5 init", 64'(dout[31:16]), 64'h0000);
    check("init dbusy", 64'(dbusy), 64'h0);

    // 2 write then read
    ren = 2'b00; we = 1'b1; wadr = 4'd3; din = 16'hBEEF;
    tick();
    we = 1'b0; ren = 2'b01; radr = {4'd0, 4'd3};
    tick();
    check("read r3", 64'(dout[15:0]), 64'hBEEF);

    // 3 bypass
    we = 1'b1; wadr = 4'd7; din = 16'h1234; ren = 2'b10; radr = {4'd7, 4'd3};
    tick();
    check("bypass r7", 64'(dout[31:16]), 64'h1234);

    // 4 scoreboard
    we = 1'b0; rsv = 1'b1; rsv_adr = 4'd4; ren = 2'b01; radr = {4'd7, 4'd4};
    tick();
    check("rsv r4 busy", 64'(dbusy[0]), 64'h1);
    rsv = 1'b0; we = 1'b1; wadr = 4'd4; din = 16'h00AA;
    tick();
    check("wb r4 data", 64'(dout[15:0]), 64'h00AA);
    check("wb r4 busy", 64'(dbusy[0]), 64'h0);
    rsv = 1'b1; din = 16'h5555;
    tick();
    check("rsv+wb r4 data", 64'(dout[15:0]), 64'h5555);
    check("rsv+wb r4 busy", 64'(dbusy[0]), 64'h1);

    // 5 port hold and dual read
    rsv = 1'b0; we = 1'b0; ren = 2'b11; radr = {4'd2, 4'd2};
    tick();
    we = 1'b1; wadr = 4'd2; din = 16'h7777; ren = 2'b01;
    tick();
    check("hold port0", 64'(dout[15:0]), 64'h7777);
    check("hold port1", 64'(dout[31:16]), 64'h0000);
    we = 1'b0; rsv = 1'b1; rsv_adr = 4'd2; ren = 2'b11;
    tick();
    check("dual dout", 64'(dout), 64'h7777_7777);
    check("dual dbusy", 64'(dbusy), 64'h3);
    ren = 2'b00; rsv = 1'b0;
    tick();

    // 6 reset mid-op, both builds
    rsv = 1'b1; rsv_adr = 4'd9;
    tick();
    we = 1'b1; wadr = 4'd9; din = 16'hFFFF;
    ren = 2'b01; radr = {4'd0, 4'd9}; ren2 = 4'b0001; radr2 = 16'h0009;
    tick();
    check("r9 pre data", 64'(dout[15:0]), 64'hFFFF);
    check("r9 pre busy", 64'(dbusy[0]), 64'h1);
    check("w r9 pre data", 64'(dout2[31:0]), 64'hFFFF_FFFF);
    check("w r9 pre busy", 64'(dbusy2[0]), 64'h1);
    we = 1'b0; rsv = 1'b0; ren = 2'b00; ren2 = 4'b0000;
    #2 reset = 1'b0;
    #1;
    check("midop dout", 64'(dout), 64'h0);
    check("midop dbusy", 64'(dbusy), 64'h0);
    check("w midop dout lo", dout2[63:0], 64'h0);
    check("w midop dout hi", dout2[127:64], 64'h0);
    check("w midop dbusy", 64'(dbusy2), 64'h0);
    tick();
    reset = 1'b1;
    ren = 2'b11; radr = {4'd0, 4'd9};
    ren2 = 4'b1111; radr2 = {4'd0, 4'd9, 4'd0, 4'd9};
    tick();
    check("post r9", 64'(dout[15:0]), 64'h0000);
    check("post r0", 64'(dout[31:16]), 64'h0001);
    check("post dbusy", 64'(dbusy), 64'h0);
    check("w post lo", dout2[63:0], 64'h0000_0001_0000_0000);
    check("w post hi", dout2[127:64], 64'h0000_0001_0000_0000);
    check("w post dbusy", 64'(dbusy2), 64'h0);
    ren = 2'b00; ren2 = 4'b0000;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
